complex_div: RTL and testbench
==============================

Name: complex_div

Overview:
- Sequential complex divider, the inverse companion of the team's complex multiplier.
- Computes (re1 + j·im1) / (re2 + j·im2) on 8-bit signed operands with a valid/ready input handshake and a one-cycle result strobe.
- Method: one product stage, then a shared-denominator restoring division of both result components in parallel, one quotient bit per cycle.
- Sits in the datapath next to the multiplier, e.g. for channel equalisation.

Parameters:
- W, 8: operand and result width (signed two's complement).
- FRAC_BITS, 0: fractional bits in the result; quotient = N·2^FRAC_BITS / D.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- re1  in  W  numerator real part, signed.
- im1  in  W  numerator imaginary part, signed.
- re2  in  W  denominator real part, signed.
- im2  in  W  denominator imaginary part, signed.
- out_valid  out  1  one-cycle strobe; results valid.
- re_res  out  W  real quotient, signed, saturated.
- im_res  out  W  imaginary quotient, signed, saturated.
- div_zero  out  1  denominator was 0+j0; valid with out_valid.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, re_res=0, im_res=0, div_zero=0, all internal registers cleared. An operation in flight is discarded and never produces out_valid.
- Arithmetic, with a=re1, b=im1, c=re2, d=im2:
  - N_re = a·c + b·d and N_im = b·c − a·d, each 2W+1 bits signed.
  - D = c² + d², 2W bits unsigned (maximum 32768 for W=8).
- Quotient width QW = 2W + FRAC_BITS.
- Division is on magnitudes |N|·2^FRAC_BITS / D. Sign is applied afterwards: negative when N<0. Default rounding is truncation toward zero.
- Saturation: final value clamped to [−2^(W−1), 2^(W−1)−1], i.e. [−128, 127].
- FSM:
  - IDLE: in_ready=1. On in_valid && in_ready, latch operands and go to PROD.
  - PROD (1 cycle): register N_re, N_im, D, both signs and both magnitudes; clear the quotient and remainder registers. Go to DIV.
  - DIV (QW cycles): each cycle shift one numerator bit into each remainder; if remainder ≥ D, subtract D and set the quotient bit. Go to DONE after bit 0.
  - DONE (1 cycle): apply sign and saturation, register re_res, im_res and div_zero, out_valid=1. Go to IDLE.
- Latency is fixed. out_valid is high during the cycle beginning QW+2 edges after the accepting edge; for defaults that is 18 cycles. Throughput is one operation per QW+3 cycles.
- No output back-pressure: out_valid is a single-cycle pulse.
- re_res, im_res and div_zero hold their values until the next DONE.
- Divide by zero (D=0): still follows the full fixed latency; re_res=0, im_res=0, div_zero=1. div_zero=0 on all other results.
- in_valid while busy is ignored; no operands are captured outside IDLE.
- Operand changes after acceptance have no effect on the operation in flight.

Optional Feature:
- Macro: COMPLEX_DIV_ROUND_EN.
- Defined: in DONE, if 2·remainder ≥ D, the magnitude is incremented before the sign is applied (round half away from zero), then saturated. Latency is unchanged.
- Undefined: truncation toward zero; the remainder is discarded.

Test Plan:
- Exact division: (10+j5)/(1+j2) → N_re=20, N_im=−15, D=5; re_res=4, im_res=−3, div_zero=0; out_valid exactly 18 cycles after the accept edge, for one cycle.
- Rounding: (7+j0)/(2+j0) → 3 (truncate) / 4 (COMPLEX_DIV_ROUND_EN). (−7+j0)/(2+j0) → −3 / −4.
- Saturation: (−128+j0)/(−1+j0) → re_res=127, im_res=0. (−128+j0)/(1+j0) → re_res=−128.
- Divide by zero: (5+j5)/(0+j0) → re_res=0, im_res=0, div_zero=1 after 18 cycles. A following valid division clears div_zero.
- Handshake: hold in_valid high with two operand sets. in_ready drops after the first accept. The second set is captured only on the edge after the out_valid cycle. Values presented while busy are never captured.
- Reset mid-operation: assert rst during DIV → outputs immediately 0, in_ready=1, no out_valid. A new operation after release completes normally with correct results.

Source files
------------

// File: rtl/complex_div_if.sv
// Operand/result bundle for complex_div: valid/ready operand side, strobed result side.
interface complex_div_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] re1;
  logic signed [W-1:0] im1;
  logic signed [W-1:0] re2;
  logic signed [W-1:0] im2;
  logic                out_valid;
  logic signed [W-1:0] re_res;
  logic signed [W-1:0] im_res;
  logic                div_zero;

  modport master (
    output in_valid, re1, im1, re2, im2,
    input  in_ready, out_valid, re_res, im_res, div_zero
  );

  modport slave (
    input  in_valid, re1, im1, re2, im2,
    output in_ready, out_valid, re_res, im_res, div_zero
  );
endinterface

// File: rtl/complex_div.sv
// Sequential complex divider: one product cycle, then restoring division of both parts
// against the shared denominator |c+jd|^2. Define COMPLEX_DIV_ROUND_EN for round-half-away.
module complex_div #(
  parameter int W         = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic         clk,
  input  logic         rst,
  complex_div_if.slave bus
);

  localparam int MW  = 2 * W;
  localparam int PW  = 2 * W + 1;
  localparam int QW  = 2 * W + FRAC_BITS;
  localparam int QW1 = QW + 1;
  localparam int CW  = $clog2(QW + 1);
  localparam logic [QW:0] POS_LIM = QW1'(2 ** (W - 1) - 1);
  localparam logic [QW:0] NEG_LIM = QW1'(2 ** (W - 1));

  typedef enum logic [1:0] {
    IDLE,
    PROD,
    DIV,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic signed [W-1:0] re1_q, re1_d;
  logic signed [W-1:0] im1_q, im1_d;
  logic signed [W-1:0] re2_q, re2_d;
  logic signed [W-1:0] im2_q, im2_d;
  logic [QW-1:0]       num_re_q, num_re_d;
  logic [QW-1:0]       num_im_q, num_im_d;
  logic [MW-1:0]       rem_re_q, rem_re_d;
  logic [MW-1:0]       rem_im_q, rem_im_d;
  logic [MW-1:0]       den_q, den_d;
  logic                neg_re_q, neg_re_d;
  logic                neg_im_q, neg_im_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        re_res_q, re_res_d;
  logic [W-1:0]        im_res_q, im_res_d;
  logic                div_zero_q, div_zero_d;

  logic signed [PW-1:0] prod_re;
  logic signed [PW-1:0] prod_im;
  logic signed [PW-1:0] prod_den;
  logic [QW:0]          mag_re;
  logic [QW:0]          mag_im;
  logic [QW-1:0]        step_num_re, step_num_im;
  logic [MW-1:0]        step_rem_re, step_rem_im;

  function automatic logic [MW-1:0] magnitude(input logic signed [PW-1:0] v);
    return v[PW-1] ? MW'(-v) : MW'(v);
  endfunction

  // Quotient bits are shifted into the vacated LSBs of the dividend register, so after
  // QW steps the dividend register holds the quotient.
  function automatic void div_step(input  logic [QW-1:0] num_i,
                                   input  logic [MW-1:0] rem_i,
                                   input  logic [MW-1:0] den_i,
                                   output logic [QW-1:0] num_o,
                                   output logic [MW-1:0] rem_o);
    logic [MW:0] trial;
    trial = {rem_i, num_i[QW-1]};
    if (trial >= {1'b0, den_i}) begin
      rem_o = MW'(trial - {1'b0, den_i});
      num_o = {num_i[QW-2:0], 1'b1};
    end else begin
      rem_o = MW'(trial);
      num_o = {num_i[QW-2:0], 1'b0};
    end
  endfunction

  function automatic logic [W-1:0] saturate(input logic neg, input logic [QW:0] m);
    if (neg) begin
      return (m > NEG_LIM) ? W'(NEG_LIM) : W'(-m);
    end
    return (m > POS_LIM) ? W'(POS_LIM) : W'(m);
  endfunction

  always_comb begin
    prod_re  = PW'(re1_q) * PW'(re2_q) + PW'(im1_q) * PW'(im2_q);
    prod_im  = PW'(im1_q) * PW'(re2_q) - PW'(re1_q) * PW'(im2_q);
    prod_den = PW'(re2_q) * PW'(re2_q) + PW'(im2_q) * PW'(im2_q);
  end

  always_comb begin
    div_step(num_re_q, rem_re_q, den_q, step_num_re, step_rem_re);
    div_step(num_im_q, rem_im_q, den_q, step_num_im, step_rem_im);
  end

  always_comb begin
    mag_re = {1'b0, num_re_q};
    mag_im = {1'b0, num_im_q};
`ifdef COMPLEX_DIV_ROUND_EN
    if ({rem_re_q, 1'b0} >= {1'b0, den_q}) mag_re = mag_re + QW1'(1);
    if ({rem_im_q, 1'b0} >= {1'b0, den_q}) mag_im = mag_im + QW1'(1);
`endif
  end

  always_comb begin
    state_d     = state_q;
    re1_d       = re1_q;
    im1_d       = im1_q;
    re2_d       = re2_q;
    im2_d       = im2_q;
    num_re_d    = num_re_q;
    num_im_d    = num_im_q;
    rem_re_d    = rem_re_q;
    rem_im_d    = rem_im_q;
    den_d       = den_q;
    neg_re_d    = neg_re_q;
    neg_im_d    = neg_im_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    re_res_d    = re_res_q;
    im_res_d    = im_res_q;
    div_zero_d  = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          re1_d   = bus.re1;
          im1_d   = bus.im1;
          re2_d   = bus.re2;
          im2_d   = bus.im2;
          state_d = PROD;
        end
      end
      PROD: begin
        num_re_d = QW'(magnitude(prod_re)) << FRAC_BITS;
        num_im_d = QW'(magnitude(prod_im)) << FRAC_BITS;
        neg_re_d = prod_re[PW-1];
        neg_im_d = prod_im[PW-1];
        den_d    = MW'(prod_den);
        rem_re_d = '0;
        rem_im_d = '0;
        cnt_d    = CW'(QW - 1);
        state_d  = DIV;
      end
      DIV: begin
        num_re_d = step_num_re;
        num_im_d = step_num_im;
        rem_re_d = step_rem_re;
        rem_im_d = step_rem_im;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (den_q == '0) begin
          re_res_d   = '0;
          im_res_d   = '0;
          div_zero_d = 1'b1;
        end else begin
          re_res_d   = saturate(neg_re_q, mag_re);
          im_res_d   = saturate(neg_im_q, mag_im);
          div_zero_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      re1_q       <= '0;
      im1_q       <= '0;
      re2_q       <= '0;
      im2_q       <= '0;
      num_re_q    <= '0;
      num_im_q    <= '0;
      rem_re_q    <= '0;
      rem_im_q    <= '0;
      den_q       <= '0;
      neg_re_q    <= 1'b0;
      neg_im_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      re_res_q    <= '0;
      im_res_q    <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      re1_q       <= re1_d;
      im1_q       <= im1_d;
      re2_q       <= re2_d;
      im2_q       <= im2_d;
      num_re_q    <= num_re_d;
      num_im_q    <= num_im_d;
      rem_re_q    <= rem_re_d;
      rem_im_q    <= rem_im_d;
      den_q       <= den_d;
      neg_re_q    <= neg_re_d;
      neg_im_q    <= neg_im_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      re_res_q    <= re_res_d;
      im_res_q    <= im_res_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.re_res    = re_res_q;
  assign bus.im_res    = im_res_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_complex_div.sv
// Directed and randomized checks of complex_div against an integer-arithmetic reference.
module tb_complex_div;
  localparam int W    = 8;
  localparam int FRAC = 0;
  localparam int LAT  = 2 * W + FRAC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  complex_div_if #(.W(W)) bus ();

  complex_div #(.W(W), .FRAC_BITS(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int qdiv(input int n, input int den);
    longint m, r;
    m = longint'(n < 0 ? -n : n) * (longint'(1) << FRAC);
    r = m % den;
    m = m / den;
`ifdef COMPLEX_DIV_ROUND_EN
    if (2 * r >= den) m++;
`else
    if (r < 0) m = -1;
`endif
    if (n < 0) m = -m;
    if (m > 127) m = 127;
    if (m < -128) m = -128;
    return int'(m);
  endfunction

  function automatic void model(input int a, input int b, input int c, input int d,
                                output int re, output int im, output int dz);
    int den;
    den = c * c + d * d;
    if (den == 0) begin
      re = 0; im = 0; dz = 1;
    end else begin
      re = qdiv(a * c + b * d, den);
      im = qdiv(b * c - a * d, den);
      dz = 0;
    end
  endfunction

  task automatic set_ops(input int a, input int b, input int c, input int d);
    bus.re1 = 8'(a);
    bus.im1 = 8'(b);
    bus.re2 = 8'(c);
    bus.im2 = 8'(d);
  endtask

  task automatic wait_result(input string tag, input int re_e, input int im_e, input int dz_e);
    int lat;
    lat = -1;
    for (int k = 1; k <= LAT + 10; k++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".re"}, bus.re_res, re_e);
    chk({tag, ".im"}, bus.im_res, im_e);
    chk({tag, ".dz"}, bus.div_zero, dz_e);
  endtask

  task automatic do_op(input string tag, input int a, input int b, input int c, input int d,
                       input bit scramble);
    int re_e, im_e, dz_e;
    model(a, b, c, d, re_e, im_e, dz_e);
    for (int k = 0; k < 40 && bus.in_ready !== 1'b1; k++) tick();
    chk({tag, ".ready"}, bus.in_ready, 1);
    set_ops(a, b, c, d);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (scramble) set_ops(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    chk({tag, ".busy"}, bus.in_ready, 0);
    wait_result(tag, re_e, im_e, dz_e);
    tick();
    chk({tag, ".pulse"}, bus.out_valid, 0);
    chk({tag, ".hold"}, bus.re_res, re_e);
  endtask

  initial begin
    int rnd_pos, rnd_neg, re_e, im_e, dz_e, seen;
`ifdef COMPLEX_DIV_ROUND_EN
    rnd_pos = 4; rnd_neg = -4;
`else
    rnd_pos = 3; rnd_neg = -3;
`endif
    bus.in_valid = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (2) tick();
    chk("rst.ready", bus.in_ready, 1);
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.re", bus.re_res, 0);
    chk("rst.im", bus.im_res, 0);
    chk("rst.dz", bus.div_zero, 0);
    rst = 1'b0;
    tick();

    do_op("exact", 10, 5, 1, 2, 1'b1);
    chk("exact.re_const", bus.re_res, 4);
    chk("exact.im_const", bus.im_res, -3);

    do_op("rnd_pos", 7, 0, 2, 0, 1'b0);
    chk("rnd_pos.const", bus.re_res, rnd_pos);
    do_op("rnd_neg", -7, 0, 2, 0, 1'b0);
    chk("rnd_neg.const", bus.re_res, rnd_neg);

    do_op("sat_pos", -128, 0, -1, 0, 1'b0);
    chk("sat_pos.const", bus.re_res, 127);
    chk("sat_pos.im", bus.im_res, 0);
    do_op("sat_neg", -128, 0, 1, 0, 1'b0);
    chk("sat_neg.const", bus.re_res, -128);

    do_op("dz", 5, 5, 0, 0, 1'b0);
    chk("dz.const", bus.div_zero, 1);
    do_op("dz_clear", 9, -4, 3, 1, 1'b0);
    chk("dz_clear.const", bus.div_zero, 0);

    // Handshake: in_valid held across two operand sets, junk presented while busy
    set_ops(20, 10, 3, 1);
    bus.in_valid = 1'b1;
    tick();
    chk("hs.busy", bus.in_ready, 0);
    set_ops(1, 1, 1, 1);
    seen = -1;
    for (int k = 1; k <= LAT + 5; k++) begin
      if (k == 10) set_ops(-50, 30, 2, -1);
      tick();
      if (bus.out_valid === 1'b1) begin
        seen = k;
        break;
      end
    end
    model(20, 10, 3, 1, re_e, im_e, dz_e);
    chk("hs.a_latency", seen, LAT);
    chk("hs.a_re", bus.re_res, re_e);
    chk("hs.a_im", bus.im_res, im_e);
    chk("hs.ready_in_valid_cycle", bus.in_ready, 1);
    tick();
    chk("hs.b_accepted", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    model(-50, 30, 2, -1, re_e, im_e, dz_e);
    wait_result("hs.b", re_e, im_e, dz_e);
    tick();

    // Reset while dividing
    do_op("pre_rst", 10, 5, 1, 2, 1'b0);
    set_ops(100, -100, 3, 4);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst.re", bus.re_res, 0);
    chk("mid_rst.im", bus.im_res, 0);
    chk("mid_rst.dz", bus.div_zero, 0);
    chk("mid_rst.valid", bus.out_valid, 0);
    chk("mid_rst.ready", bus.in_ready, 1);
    repeat (2) tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("mid_rst.no_valid", seen, 0);
    do_op("post_rst", -90, 45, -7, 2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int a, b, c, d;
      a = int'($signed(8'($urandom)));
      b = int'($signed(8'($urandom)));
      if (i % 2 == 0) begin
        c = int'($urandom_range(0, 14)) - 7;
        d = int'($urandom_range(0, 14)) - 7;
      end else begin
        c = int'($signed(8'($urandom)));
        d = int'($signed(8'($urandom)));
      end
      do_op($sformatf("rand%0d", i), a, b, c, d, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
